// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM sequencing a shared multicycle RV32I datapath.
module multicycle_ctrl #(
    parameter int WAIT_LIMIT = 0,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       retire,
    output logic       trap,
    output logic       trap_cause
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic             waiting, timeout, alu_ok, br_ok;
    logic [2:0]       alu_ctl;

    assign waiting = state inside {FETCH, MEMREAD, MEMWRITE};
    // The limit-th idle cycle traps unless mem_ready arrives in that same cycle.
    assign timeout = WAIT_LIMIT != 0 && waiting && !mem_ready && cnt == CNT_W'(WAIT_LIMIT - 1);
    assign alu_ok  = funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};
    assign br_ok   = funct3[2:1] == 2'b00;
    assign alu_ctl = funct3 == 3'b010 ? 3'b101 :
                     funct3 == 3'b110 ? 3'b011 :
                     funct3 == 3'b111 ? 3'b010 :
                     {2'b00, state == EXECR && funct7b5 && funct3 == 3'b000};
    assign trap    = state == TRAP;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            cnt        <= '0;
            trap_cause <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= (waiting && state_n == state) ? cnt + 1'b1 : '0;
            trap_cause <= (state != TRAP && state_n == TRAP) ? timeout : trap_cause;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            FETCH:    state_n = mem_ready ? DECODE : timeout ? TRAP : FETCH;
            DECODE:   state_n = (op == 7'b0000011 || op == 7'b0100011) ? MEMADR :
                                op == 7'b0110011 ? EXECR :
                                op == 7'b0010011 ? EXECI :
                                op == 7'b1100011 ? BRANCH :
                                op == 7'b1101111 ? JAL : TRAP;
            MEMADR:   state_n = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  state_n = mem_ready ? MEMWB : timeout ? TRAP : MEMREAD;
            MEMWB:    state_n = FETCH;
            MEMWRITE: state_n = mem_ready ? FETCH : timeout ? TRAP : MEMWRITE;
            EXECR,
            EXECI:    state_n = alu_ok ? ALUWB : TRAP;
            ALUWB:    state_n = FETCH;
            BRANCH:   state_n = br_ok ? FETCH : TRAP;
            JAL:      state_n = ALUWB;
            default:  state_n = TRAP;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        ImmSrc     = 3'b000;
        retire     = 1'b0;
        case (state)
            FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b010;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = op[5] ? 3'b001 : 3'b000;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                MemRead = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                retire   = mem_ready;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_ctl;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_ctl;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = 3'b001;
                PCWrite    = br_ok && (Zero ^ funct3[0]);
                retire     = br_ok;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
        if (!reset) {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, retire} = '0;
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-instruction reference model pushes expected per-cycle
// outputs into a scoreboard; a monitor compares them on the falling edge.
module tb_multicycle_ctrl;
    localparam int WL = 4;

    typedef struct packed {
        logic       pcw, adr, mrd, mwr, irw, rgw;
        logic [1:0] res, sa, sb;
        logic [2:0] alu, imm;
        logic       ret, trp, cause;
    } outs_t;
    typedef struct {
        int    cyc;
        outs_t o;
    } exp_t;

    logic       clk = 0, reset = 0;
    logic [6:0] op = 0;
    logic [2:0] funct3 = 0;
    logic       funct7b5 = 0, Zero = 0, mem_ready = 0;
    logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, retire, trap, trap_cause;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;
    outs_t      act;
    exp_t       sbq[$];
    int         cyc = 0, passed = 0, total = 0;

    multicycle_ctrl #(.WAIT_LIMIT(WL), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .retire(retire), .trap(trap),
        .trap_cause(trap_cause)
    );

    assign act = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUControl, ImmSrc, retire, trap, trap_cause};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            total++;
            $display("FAIL missed cyc=%0d got=none exp=%h", sbq[0].cyc, sbq[0].o);
            void'(sbq.pop_front());
        end
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            total++;
            if (act === sbq[0].o) passed++;
            else $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc, act, sbq[0].o);
            void'(sbq.pop_front());
        end
    end

    function automatic outs_t ov(logic [1:0] sa, sb, res, logic [2:0] alu, imm);
        outs_t o = '0;
        o.sa = sa; o.sb = sb; o.res = res; o.alu = alu; o.imm = imm;
        return o;
    endfunction

    function automatic int wr();
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 5)) : int'($urandom_range(0, 2));
    endfunction

    // One instruction: w0/w1 = idle cycles before fetch/data mem_ready; abort_at = cycle index to pull reset.
    task automatic run(input logic [6:0] o_op, input logic [2:0] f3, input logic f7, z,
                       input int w0, w1, abort_at);
        logic  rq[$];
        outs_t eq[$];
        outs_t v, wb;
        logic [2:0] alu;
        bit    trp, ok, ld, st, rt, it, br, jl;
        logic  cause;
        int    ab, c0;
        trp = 0; cause = 0; ab = abort_at;
        ld = o_op == 7'b0000011; st = o_op == 7'b0100011; rt = o_op == 7'b0110011;
        it = o_op == 7'b0010011; br = o_op == 7'b1100011; jl = o_op == 7'b1101111;
        wb = '0; wb.rgw = 1; wb.ret = 1;
        v = ov(2'b00, 2'b10, 2'b10, 3'b000, 3'b000); v.mrd = 1;
        for (int i = 0; i < w0 && i < WL; i++) begin rq.push_back(0); eq.push_back(v); end
        if (w0 >= WL) begin trp = 1; cause = 1; end
        else begin
            v.pcw = 1; v.irw = 1;
            rq.push_back(1); eq.push_back(v);
            rq.push_back(1'($urandom_range(0, 1))); eq.push_back(ov(2'b01, 2'b01, 2'b00, 3'b000, 3'b010));
            if (ld || st) begin
                rq.push_back(1'($urandom_range(0, 1)));
                eq.push_back(ov(2'b10, 2'b01, 2'b00, 3'b000, st ? 3'b001 : 3'b000));
                v = '0; v.adr = 1; v.mrd = ld; v.mwr = st;
                for (int i = 0; i < w1 && i < WL; i++) begin rq.push_back(0); eq.push_back(v); end
                if (w1 >= WL) begin trp = 1; cause = 1; end
                else begin
                    v.ret = st;
                    rq.push_back(1); eq.push_back(v);
                    if (ld) begin
                        v = '0; v.res = 2'b01; v.rgw = 1; v.ret = 1;
                        rq.push_back(1'($urandom_range(0, 1))); eq.push_back(v);
                    end
                end
            end else if (rt || it) begin
                ok  = f3 inside {3'd0, 3'd2, 3'd6, 3'd7};
                alu = f3 == 3'd0 ? {2'b00, rt && f7} : f3 == 3'd2 ? 3'd5 :
                      f3 == 3'd6 ? 3'd3 : f3 == 3'd7 ? 3'd2 : 3'd0;
                rq.push_back(1'($urandom_range(0, 1)));
                eq.push_back(ov(2'b10, it ? 2'b01 : 2'b00, 2'b00, alu, 3'b000));
                if (ok) begin rq.push_back(1'($urandom_range(0, 1))); eq.push_back(wb); end
                else trp = 1;
            end else if (br) begin
                ok = f3 < 3'd2;
                v = ov(2'b10, 2'b00, 2'b00, 3'b001, 3'b000);
                v.pcw = ok && (f3 == 3'd0 ? z : !z);
                v.ret = ok;
                rq.push_back(1'($urandom_range(0, 1))); eq.push_back(v);
                if (!ok) trp = 1;
            end else if (jl) begin
                v = ov(2'b01, 2'b10, 2'b00, 3'b000, 3'b000); v.pcw = 1;
                rq.push_back(1'($urandom_range(0, 1))); eq.push_back(v);
                rq.push_back(1'($urandom_range(0, 1))); eq.push_back(wb);
            end else trp = 1;
        end
        if (trp) begin
            v = '0; v.trp = 1; v.cause = cause;
            repeat (2) begin rq.push_back(1'($urandom_range(0, 1))); eq.push_back(v); end
            ab = eq.size();
        end
        if (ab >= 0) begin
            while (eq.size() > ab) begin void'(eq.pop_back()); void'(rq.pop_back()); end
            v = ov(2'b00, 2'b10, 2'b10, 3'b000, 3'b000);
            repeat (2) begin rq.push_back(1'($urandom_range(0, 1))); eq.push_back(v); end
        end
        @(posedge clk); #1;
        c0 = cyc;
        foreach (eq[i]) sbq.push_back('{c0 + i, eq[i]});
        op = o_op; funct3 = f3; funct7b5 = f7; Zero = z;
        for (int i = 0; i < eq.size(); i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            reset = !(ab >= 0 && i >= ab);
            mem_ready = rq[i];
        end
    endtask

    initial begin
        logic [6:0] o;
        repeat (2) begin
            @(posedge clk); #1;
            sbq.push_back('{cyc, ov(2'b00, 2'b10, 2'b10, 3'b000, 3'b000)});
        end
        run(7'b0110011, 3'd0, 0, 0, 0, 0, -1);
        run(7'b0110011, 3'd0, 1, 0, 0, 0, -1);
        run(7'b0010011, 3'd0, 1, 0, 0, 0, -1);
        run(7'b0110011, 3'd2, 0, 0, 0, 0, -1);
        run(7'b0010011, 3'd6, 0, 0, 0, 0, -1);
        run(7'b0110011, 3'd7, 0, 0, 0, 0, -1);
        run(7'b0000011, 3'd2, 0, 0, 0, 3, -1);
        run(7'b0100011, 3'd2, 0, 0, 1, 0, -1);
        run(7'b1100011, 3'd0, 0, 1, 0, 0, -1);
        run(7'b1100011, 3'd0, 0, 0, 0, 0, -1);
        run(7'b1100011, 3'd1, 0, 0, 0, 0, -1);
        run(7'b1101111, 3'd0, 0, 0, 0, 0, -1);
        run(7'b0110011, 3'd0, 0, 0, 3, 0, -1);
        run(7'b0110011, 3'd0, 0, 0, 4, 0, -1);
        run(7'b1111111, 3'd0, 0, 0, 0, 0, -1);
        run(7'b0100011, 3'd2, 0, 0, 0, 5, 4);
        run(7'b0000011, 3'd2, 0, 0, 0, 4, -1);
        run(7'b0100011, 3'd2, 0, 0, 0, 3, -1);
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 6))
                0: o = 7'b0000011;
                1: o = 7'b0100011;
                2: o = 7'b0110011;
                3: o = 7'b0010011;
                4: o = 7'b1100011;
                5: o = 7'b1101111;
                default: o = 7'($urandom_range(0, 127));
            endcase
            run(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                wr(), wr(), ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 5)) : -1);
        end
        repeat (3) @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            total++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", sbq.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
